// File: rtl/mem_l0_xfer_sched_pkg.sv
// Shared definitions for the SRAM <-> L0 transfer sequencer: channel FSM
// encoding, transfer direction codes and default geometry/latency values.
package mem_l0_xfer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } xfer_state_e;

  localparam logic DIR_LOAD  = 1'b0;  // SRAM -> L0
  localparam logic DIR_STORE = 1'b1;  // L0 -> SRAM

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_MEM_AW     = 4;
  localparam int DEF_L0_AW      = 3;
  localparam int DEF_MEM_RD_LAT = 2;
  localparam int DEF_L0_RD_LAT  = 1;

  // Larger of two elaboration-time integers (sizes the shared latency pipe).
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_l0_xfer_sched_if.sv
// Bundle of the controller request side and the SRAM/L0 enable side of the
// transfer sequencer. The sequencer uses the slave view.
interface mem_l0_xfer_sched_if
  import mem_l0_xfer_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int L0_AW  = DEF_L0_AW
);
  logic [NUM_CH-1:0]           xfer_start;
  logic [NUM_CH-1:0]           xfer_dir;
  logic [NUM_CH*(L0_AW+1)-1:0] xfer_len;
  logic [NUM_CH*MEM_AW-1:0]    xfer_base;
  logic [NUM_CH-1:0]           xfer_abort;
  logic [NUM_CH-1:0]           busy;
  logic [NUM_CH-1:0]           done;
  logic [NUM_CH-1:0]           mem_cs;
  logic [NUM_CH-1:0]           mem_re;
  logic [NUM_CH-1:0]           mem_we;
  logic [NUM_CH*MEM_AW-1:0]    mem_addr;
  logic [NUM_CH-1:0]           l0_cs;
  logic [NUM_CH-1:0]           l0_re;
  logic [NUM_CH-1:0]           l0_we;
  logic [NUM_CH*L0_AW-1:0]     l0_raddr;
  logic [NUM_CH*L0_AW-1:0]     l0_waddr;

  modport master (
    output xfer_start, xfer_dir, xfer_len, xfer_base, xfer_abort,
    input  busy, done, mem_cs, mem_re, mem_we, mem_addr,
    input  l0_cs, l0_re, l0_we, l0_raddr, l0_waddr
  );

  modport slave (
    input  xfer_start, xfer_dir, xfer_len, xfer_base, xfer_abort,
    output busy, done, mem_cs, mem_re, mem_we, mem_addr,
    output l0_cs, l0_re, l0_we, l0_raddr, l0_waddr
  );
endinterface

// File: rtl/mem_l0_xfer_sched_chan_ctrl.sv
// One transfer channel: FSM, read index and the {valid, k} latency pipe that
// re-times each read into the matching write on the other memory.
// pipe[0] is the read presented this cycle; pipe[j] is the read from j cycles ago.
module mem_l0_xfer_sched_chan_ctrl
  import mem_l0_xfer_sched_pkg::*;
#(
  parameter int MEM_AW     = DEF_MEM_AW,
  parameter int L0_AW      = DEF_L0_AW,
  parameter int MEM_RD_LAT = DEF_MEM_RD_LAT,
  parameter int L0_RD_LAT  = DEF_L0_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [L0_AW:0]    len,
  input  logic [MEM_AW-1:0] base,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_re,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              l0_cs,
  output logic              l0_re,
  output logic              l0_we,
  output logic [L0_AW-1:0]  l0_raddr,
  output logic [L0_AW-1:0]  l0_waddr
);
  localparam int              PIPE_D  = max_int(MEM_RD_LAT, L0_RD_LAT);
  localparam logic [L0_AW:0]  LEN_ONE = 1;
  localparam logic [L0_AW-1:0] K_ONE  = 1;

  xfer_state_e       state_reg, state_next;
  logic              dir_reg, dir_next;
  logic [L0_AW:0]    len_reg, len_next;
  logic [MEM_AW-1:0] base_reg, base_next;
  logic [PIPE_D-1:0] pipe_v_reg, pipe_v_next;
  logic [L0_AW-1:0]  pipe_k_reg [PIPE_D];
  logic [L0_AW-1:0]  pipe_k_next [PIPE_D];

  logic              rd_v, wr_v, pending, kill;
  logic [L0_AW-1:0]  rd_k, wr_k;
  int                lat_cur;

  logic              busy_reg, done_reg, mem_cs_reg, mem_re_reg, mem_we_reg;
  logic              l0_cs_reg, l0_re_reg, l0_we_reg;
  logic              busy_next, done_next, mem_cs_next, mem_re_next, mem_we_next;
  logic              l0_cs_next, l0_re_next, l0_we_next;
  logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
  logic [L0_AW-1:0]  l0_raddr_reg, l0_raddr_next, l0_waddr_reg, l0_waddr_next;

  // Next-state, next-read, pipe shift and next-output computation.
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    len_next   = len_reg;
    base_next  = base_reg;
    rd_v       = 1'b0;
    rd_k       = '0;
    kill       = abort && (state_reg != ST_IDLE);
    lat_cur    = (dir_reg == DIR_STORE) ? L0_RD_LAT : MEM_RD_LAT;

    // Writes still owed to cycles after this one sit in pipe[0 .. lat-1].
    pending = 1'b0;
    for (int j = 0; j < PIPE_D; j++)
      if (pipe_v_reg[j] && (j < lat_cur)) pending = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          dir_next  = dir;
          len_next  = len;
          base_next = base;
          if (len == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ISSUE;
            rd_v       = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (({1'b0, pipe_k_reg[0]} + LEN_ONE) == len_reg) begin
          state_next = ST_FLUSH;
        end else begin
          rd_v = 1'b1;
          rd_k = pipe_k_reg[0] + K_ONE;
        end
      end
      ST_FLUSH: if (!pending) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (kill) begin
      state_next = ST_IDLE;
      rd_v       = 1'b0;
      rd_k       = '0;
    end

    // The write shown next cycle is the read issued lat-1 cycles before now.
    if (dir_next == DIR_STORE) begin
      wr_v = pipe_v_reg[L0_RD_LAT-1];
      wr_k = pipe_k_reg[L0_RD_LAT-1];
    end else begin
      wr_v = pipe_v_reg[MEM_RD_LAT-1];
      wr_k = pipe_k_reg[MEM_RD_LAT-1];
    end
    if (kill) wr_v = 1'b0;

    pipe_v_next[0] = rd_v;
    pipe_k_next[0] = rd_k;
    for (int j = 1; j < PIPE_D; j++) begin
      pipe_v_next[j] = pipe_v_reg[j-1];
      pipe_k_next[j] = pipe_k_reg[j-1];
    end
    // Stale entries deeper than the active latency must not leak into the next job.
    if (kill || (state_next == ST_DONE) || (state_next == ST_IDLE)) begin
      pipe_v_next = '0;
      for (int j = 0; j < PIPE_D; j++) pipe_k_next[j] = '0;
    end

    busy_next     = (state_next == ST_ISSUE) || (state_next == ST_FLUSH);
    done_next     = (state_next == ST_DONE);
    mem_cs_next   = 1'b0;
    mem_re_next   = 1'b0;
    mem_we_next   = 1'b0;
    mem_addr_next = '0;
    l0_cs_next    = 1'b0;
    l0_re_next    = 1'b0;
    l0_we_next    = 1'b0;
    l0_raddr_next = '0;
    l0_waddr_next = '0;
    if (dir_next == DIR_LOAD) begin
      mem_cs_next = rd_v;
      mem_re_next = rd_v;
      if (rd_v) mem_addr_next = base_next + MEM_AW'(rd_k);
      l0_cs_next  = wr_v;
      l0_we_next  = wr_v;
      if (wr_v) l0_waddr_next = wr_k;
    end else begin
      l0_cs_next  = rd_v;
      l0_re_next  = rd_v;
      if (rd_v) l0_raddr_next = rd_k;
      mem_cs_next = wr_v;
      mem_we_next = wr_v;
      if (wr_v) mem_addr_next = base_next + MEM_AW'(wr_k);
    end
  end

  // Channel state, latency pipe and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      dir_reg      <= DIR_LOAD;
      len_reg      <= '0;
      base_reg     <= '0;
      pipe_v_reg   <= '0;
      for (int j = 0; j < PIPE_D; j++) pipe_k_reg[j] <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mem_cs_reg   <= 1'b0;
      mem_re_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      l0_cs_reg    <= 1'b0;
      l0_re_reg    <= 1'b0;
      l0_we_reg    <= 1'b0;
      l0_raddr_reg <= '0;
      l0_waddr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      len_reg      <= len_next;
      base_reg     <= base_next;
      pipe_v_reg   <= pipe_v_next;
      for (int j = 0; j < PIPE_D; j++) pipe_k_reg[j] <= pipe_k_next[j];
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      mem_cs_reg   <= mem_cs_next;
      mem_re_reg   <= mem_re_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      l0_cs_reg    <= l0_cs_next;
      l0_re_reg    <= l0_re_next;
      l0_we_reg    <= l0_we_next;
      l0_raddr_reg <= l0_raddr_next;
      l0_waddr_reg <= l0_waddr_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign mem_cs   = mem_cs_reg;
  assign mem_re   = mem_re_reg;
  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign l0_cs    = l0_cs_reg;
  assign l0_re    = l0_re_reg;
  assign l0_we    = l0_we_reg;
  assign l0_raddr = l0_raddr_reg;
  assign l0_waddr = l0_waddr_reg;

endmodule

// File: rtl/mem_l0_xfer_sched.sv
// NUM_CH independent SRAM <-> L0 transfer channels; each channel is a
// self-contained controller whose outputs are packed onto the bus here.
module mem_l0_xfer_sched
  import mem_l0_xfer_sched_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int MEM_AW     = DEF_MEM_AW,
  parameter int L0_AW      = DEF_L0_AW,
  parameter int MEM_RD_LAT = DEF_MEM_RD_LAT,
  parameter int L0_RD_LAT  = DEF_L0_RD_LAT
) (
  input logic               clk,
  input logic               rst,
  mem_l0_xfer_sched_if.slave bus
);
  logic [NUM_CH-1:0]        busy_w, done_w, mem_cs_w, mem_re_w, mem_we_w;
  logic [NUM_CH-1:0]        l0_cs_w, l0_re_w, l0_we_w;
  logic [NUM_CH*MEM_AW-1:0] mem_addr_w;
  logic [NUM_CH*L0_AW-1:0]  l0_raddr_w, l0_waddr_w;

  // One controller per channel, sliced out of the packed request fields.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    mem_l0_xfer_sched_chan_ctrl #(
      .MEM_AW    (MEM_AW),
      .L0_AW     (L0_AW),
      .MEM_RD_LAT(MEM_RD_LAT),
      .L0_RD_LAT (L0_RD_LAT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .start   (bus.xfer_start[gi]),
      .dir     (bus.xfer_dir[gi]),
      .len     (bus.xfer_len[gi*(L0_AW+1) +: (L0_AW+1)]),
      .base    (bus.xfer_base[gi*MEM_AW +: MEM_AW]),
      .abort   (bus.xfer_abort[gi]),
      .busy    (busy_w[gi]),
      .done    (done_w[gi]),
      .mem_cs  (mem_cs_w[gi]),
      .mem_re  (mem_re_w[gi]),
      .mem_we  (mem_we_w[gi]),
      .mem_addr(mem_addr_w[gi*MEM_AW +: MEM_AW]),
      .l0_cs   (l0_cs_w[gi]),
      .l0_re   (l0_re_w[gi]),
      .l0_we   (l0_we_w[gi]),
      .l0_raddr(l0_raddr_w[gi*L0_AW +: L0_AW]),
      .l0_waddr(l0_waddr_w[gi*L0_AW +: L0_AW])
    );
  end

  assign bus.busy     = busy_w;
  assign bus.done     = done_w;
  assign bus.mem_cs   = mem_cs_w;
  assign bus.mem_re   = mem_re_w;
  assign bus.mem_we   = mem_we_w;
  assign bus.mem_addr = mem_addr_w;
  assign bus.l0_cs    = l0_cs_w;
  assign bus.l0_re    = l0_re_w;
  assign bus.l0_we    = l0_we_w;
  assign bus.l0_raddr = l0_raddr_w;
  assign bus.l0_waddr = l0_waddr_w;

endmodule

// File: tb/tb_mem_l0_xfer_sched.sv
// Directed bench for the transfer sequencer: load, store with address wrap,
// parallel channels, abort, ignored starts and mid-transfer reset.
module tb_mem_l0_xfer_sched;
  localparam int NUM_CH = 3;
  localparam int MEM_AW = 4;
  localparam int L0_AW  = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_l0_xfer_sched_if #(.NUM_CH(NUM_CH), .MEM_AW(MEM_AW), .L0_AW(L0_AW)) bus ();

  mem_l0_xfer_sched #(
    .NUM_CH(NUM_CH), .MEM_AW(MEM_AW), .L0_AW(L0_AW), .MEM_RD_LAT(2), .L0_RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Expected channel snapshot: {busy,done,mem_cs,mem_re,mem_we,mem_addr,l0_cs,l0_re,l0_we,l0_raddr,l0_waddr}
  function automatic logic [17:0] pk(input int b, input int d, input int mcs, input int mre,
                                     input int mwe, input int ma, input int lcs, input int lre,
                                     input int lwe, input int lra, input int lwa);
    return {b[0], d[0], mcs[0], mre[0], mwe[0], ma[3:0], lcs[0], lre[0], lwe[0], lra[2:0], lwa[2:0]};
  endfunction

  function automatic logic [17:0] snap(input int ch);
    return {bus.busy[ch], bus.done[ch], bus.mem_cs[ch], bus.mem_re[ch], bus.mem_we[ch],
            bus.mem_addr[ch*MEM_AW +: MEM_AW], bus.l0_cs[ch], bus.l0_re[ch], bus.l0_we[ch],
            bus.l0_raddr[ch*L0_AW +: L0_AW], bus.l0_waddr[ch*L0_AW +: L0_AW]};
  endfunction

  task automatic chk(input string tag, input int ch, input logic [17:0] exp);
    logic [17:0] got;
    got = snap(ch);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s ch%0d: observed %05h expected %05h", tag, ch, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int c = 0; c < NUM_CH; c++) chk(tag, c, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int st, input int dr, input int ln, input int bs);
    bus.xfer_start[ch]                         = st[0];
    bus.xfer_dir[ch]                           = dr[0];
    bus.xfer_len[ch*(L0_AW+1) +: (L0_AW+1)]    = ln[3:0];
    bus.xfer_base[ch*MEM_AW +: MEM_AW]         = bs[3:0];
  endtask

  initial begin
    rst            = 1'b1;
    bus.xfer_start = '0;
    bus.xfer_dir   = '0;
    bus.xfer_len   = '0;
    bus.xfer_base  = '0;
    bus.xfer_abort = '0;
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Load ch0, base 4, len 4
    set_ch(0, 1, 0, 4, 4);
    tick(); set_ch(0, 0, 0, 0, 0);
    chk("t1_c1", 0, pk(1,0,1,1,0,4,0,0,0,0,0)); chk("t1_c1", 1, '0); chk("t1_c1", 2, '0);
    tick(); chk("t1_c2", 0, pk(1,0,1,1,0,5,0,0,0,0,0));
    tick(); chk("t1_c3", 0, pk(1,0,1,1,0,6,1,0,1,0,0));
    tick(); chk("t1_c4", 0, pk(1,0,1,1,0,7,1,0,1,0,1));
    tick(); chk("t1_c5", 0, pk(1,0,0,0,0,0,1,0,1,0,2));
    tick(); chk("t1_c6", 0, pk(1,0,0,0,0,0,1,0,1,0,3));
    tick(); chk("t1_c7", 0, pk(0,1,0,0,0,0,0,0,0,0,0));
    tick(); chk("t1_c8", 0, '0);

    // Store ch2, base 14, len 4 (SRAM address wraps)
    set_ch(2, 1, 1, 4, 14);
    tick(); set_ch(2, 0, 0, 0, 0);
    chk("t2_c1", 2, pk(1,0,0,0,0,0,1,1,0,0,0));
    tick(); chk("t2_c2", 2, pk(1,0,1,0,1,14,1,1,0,1,0));
    tick(); chk("t2_c3", 2, pk(1,0,1,0,1,15,1,1,0,2,0));
    tick(); chk("t2_c4", 2, pk(1,0,1,0,1,0,1,1,0,3,0));
    tick(); chk("t2_c5", 2, pk(1,0,1,0,1,1,0,0,0,0,0));
    tick(); chk("t2_c6", 2, pk(0,1,0,0,0,0,0,0,0,0,0));
    tick(); chk("t2_c7", 2, '0);

    // Parallel starts: ch0 load len 8 base 12, ch1 load len 2 base 8, ch2 len 0
    set_ch(0, 1, 0, 8, 12); set_ch(1, 1, 0, 2, 8); set_ch(2, 1, 1, 0, 3);
    tick(); set_ch(0, 0, 0, 0, 0); set_ch(2, 0, 0, 0, 0);
    set_ch(1, 1, 0, 2, 0);  // start while busy: must be ignored
    chk("t3_c1", 0, pk(1,0,1,1,0,12,0,0,0,0,0));
    chk("t3_c1", 1, pk(1,0,1,1,0,8,0,0,0,0,0));
    chk("t3_c1", 2, pk(0,1,0,0,0,0,0,0,0,0,0));
    tick(); set_ch(1, 0, 0, 0, 0);
    chk("t3_c2", 0, pk(1,0,1,1,0,13,0,0,0,0,0));
    chk("t3_c2", 1, pk(1,0,1,1,0,9,0,0,0,0,0));
    chk("t3_c2", 2, '0);
    tick();
    chk("t3_c3", 0, pk(1,0,1,1,0,14,1,0,1,0,0));
    chk("t3_c3", 1, pk(1,0,0,0,0,0,1,0,1,0,0));
    tick();
    chk("t3_c4", 0, pk(1,0,1,1,0,15,1,0,1,0,1));
    chk("t3_c4", 1, pk(1,0,0,0,0,0,1,0,1,0,1));
    tick();
    chk("t3_c5", 0, pk(1,0,1,1,0,0,1,0,1,0,2));
    chk("t3_c5", 1, pk(0,1,0,0,0,0,0,0,0,0,0));
    set_ch(1, 1, 0, 2, 0);  // start in DONE: must be ignored
    tick(); set_ch(1, 0, 0, 0, 0);
    chk("t3_c6", 0, pk(1,0,1,1,0,1,1,0,1,0,3));
    chk("t3_c6", 1, '0);
    tick();
    chk("t3_c7", 0, pk(1,0,1,1,0,2,1,0,1,0,4));
    chk("t3_c7", 1, '0);
    tick(); chk("t3_c8", 0, pk(1,0,1,1,0,3,1,0,1,0,5));
    tick(); chk("t3_c9", 0, pk(1,0,0,0,0,0,1,0,1,0,6));
    tick(); chk("t3_c10", 0, pk(1,0,0,0,0,0,1,0,1,0,7));
    tick();
    chk("t3_c11", 0, pk(0,1,0,0,0,0,0,0,0,0,0));
    chk("t3_c11", 1, '0); chk("t3_c11", 2, '0);
    tick(); chk("t3_c12", 0, '0);

    // Abort ch0 in its third ISSUE cycle, then restart immediately
    set_ch(0, 1, 0, 8, 2);
    tick(); set_ch(0, 0, 0, 0, 0);
    chk("t4_c1", 0, pk(1,0,1,1,0,2,0,0,0,0,0));
    tick(); chk("t4_c2", 0, pk(1,0,1,1,0,3,0,0,0,0,0));
    tick(); chk("t4_c3", 0, pk(1,0,1,1,0,4,1,0,1,0,0));
    bus.xfer_abort[0] = 1'b1;
    tick(); bus.xfer_abort[0] = 1'b0;
    chk("t4_abort", 0, '0);
    set_ch(0, 1, 0, 1, 5);
    tick(); set_ch(0, 0, 0, 0, 0);
    chk("t4_restart", 0, pk(1,0,1,1,0,5,0,0,0,0,0));
    tick(); chk("t4_flush", 0, pk(1,0,0,0,0,0,0,0,0,0,0));
    tick(); chk("t4_wr", 0, pk(1,0,0,0,0,0,1,0,1,0,0));
    tick(); chk("t4_done", 0, pk(0,1,0,0,0,0,0,0,0,0,0));
    tick(); chk("t4_idle", 0, '0);

    // Reset during FLUSH on ch1
    set_ch(1, 1, 0, 2, 6);
    tick(); set_ch(1, 0, 0, 0, 0);
    chk("t5_c1", 1, pk(1,0,1,1,0,6,0,0,0,0,0));
    tick(); chk("t5_c2", 1, pk(1,0,1,1,0,7,0,0,0,0,0));
    tick(); chk("t5_c3", 1, pk(1,0,0,0,0,0,1,0,1,0,0));
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_idle("t5_rst");
    tick(); chk_idle("t5_after");
    tick(); chk_idle("t5_after2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
